rs_branch_multi: RTL and testbench
==================================

RS_BRANCH_MULTI -- requirements
Module: rs_branch_multi

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of entries (power of two, 2..16).
REQ-002 SHALL provide parameters DATA_W 32, ADDR_W 32, TAG_W 4, OP_W 6: data, address, tag and op widths.
REQ-003 SHALL provide parameter TAG_FREE, default 0, tag value meaning "operand valid".
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  the only clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rdy  in  1  global enable; when 0, all state holds.
- alloc_en  in  1  decoder allocation request.
- alloc_op  in  OP_W  branch op.
- alloc_data1 / alloc_data2  in  DATA_W  operand values.
- alloc_tag1 / alloc_tag2  in  TAG_W  operand tags.
- alloc_pc / alloc_offset  in  ADDR_W  PC and offset.
- stall  in  1  suppresses allocation.
- flush  in  1  mispredict; discard all entries.
- en_alu_rst1, en_alu_rst2, en_mem_rst  in  1 each  result broadcast valids.
- alu_rst_tag1, alu_rst_tag2, mem_rst_tag  in  TAG_W each  broadcast tags.
- alu_rst_data1, alu_rst_data2, mem_rst_data  in  DATA_W each  broadcast data.
- full  out  1  no free entry.
- ex_branch_en  out  1  issue valid.
- exsrc1_out / exsrc2_out  out  DATA_W  resolved operands.
- expc_out / exoffset_out  out  ADDR_W  PC and offset.
- exaluop_out  out  OP_W  op.

Function
REQ-005 full SHALL be combinational from registered busy bits: 1 iff all DEPTH entries are busy.
REQ-006 An allocation SHALL occur iff alloc_en && !stall && !full && !flush && rdy; it writes the lowest-index non-busy entry.
REQ-007 At allocation, an operand whose tag matches an enabled broadcast in the same cycle SHALL be stored with the broadcast data and tag TAG_FREE.
REQ-008 Each busy entry with tag != TAG_FREE SHALL capture data and set tag TAG_FREE when any enabled broadcast tag matches; priority on multiple matches: alu1, then mem, then alu2.
REQ-009 An entry SHALL be ready when busy and both operands are TAG_FREE after same-cycle wakeup (REQ-008 bypass included).
REQ-010 Each cycle with rdy=1 and flush=0, exactly one ready entry, if any exists, SHALL be issued per REQ-023; its busy bit clears at that edge.
REQ-011 Issue outputs SHALL be registered: one cycle after selection, ex_branch_en=1 with that entry's bypassed operands, pc, offset and op; otherwise ex_branch_en=0 and all data outputs 0.
REQ-012 Minimum latency SHALL be one cycle: an entry allocated with both tags TAG_FREE at edge N is selectable in cycle N and appears on the outputs after edge N+1.
REQ-013 A slot freed by issue SHALL NOT be reallocated in the same cycle; full deasserts the following cycle.
REQ-014 flush=1 SHALL clear all busy bits and ex_branch_en at the next edge, with no allocation and no issue that cycle.
REQ-015 With rdy=0, busy bits, entry contents and outputs SHALL hold, and broadcasts SHALL be ignored.
REQ-016 Entries with TAG_FREE operands SHALL ignore broadcasts carrying TAG_FREE.

Reset
REQ-017 When rst=0, all busy bits SHALL clear immediately, without waiting for a clock edge.
REQ-018 When rst=0, entry tags SHALL be TAG_FREE, data, PC and offset 0, op 0.
REQ-019 When rst=0, full=0, ex_branch_en=0 and all issue data outputs 0.
REQ-020 Deasserting rst mid-operation SHALL leave the block empty; there is no partial recovery.
REQ-021 The first allocation SHALL be accepted on the first rising edge after rst returns to 1.

Configuration
REQ-022 Macro RS_BRANCH_AGE_EN SHALL select the issue policy.
REQ-023 With RS_BRANCH_AGE_EN defined, the oldest ready entry (earliest allocation) issues, tracked by a DEPTH x DEPTH older-than matrix. Without it, the lowest-index ready entry issues and no age state is built.

Verification
REQ-024 Allocate op=BEQ, tags 0/0, data 5/5, pc 0x100, offset 8 -> next cycle ex_branch_en=1, src 5/5, pc 0x100, offset 8.
REQ-025 Allocate with tag1=3; two cycles later en_alu_rst2=1, tag 3, data 0x55 -> issue one edge later with exsrc1_out=0x55. Alloc in the same cycle as that broadcast -> same data captured.
REQ-026 Fill DEPTH=4 with unready entries -> full=1; fifth alloc_en is ignored. One entry wakes and issues -> full=0 the next cycle, not the same cycle.
REQ-027 AGE_EN: allocate to slot 2 then slot 0 (slot 0 freed earlier), wake both in the same cycle -> slot 2 issues first. Without AGE_EN -> slot 0 issues first.
REQ-028 Three entries busy, flush=1 together with alloc_en=1 -> all busy cleared, nothing allocated, ex_branch_en=0.
REQ-029 rst=0 asserted between edges with busy entries -> full and ex_branch_en drop immediately.

Source files
------------

// File: rtl/rs_branch_multi.sv
// rs_branch_multi: branch reservation station with result-bus wakeup and single issue per cycle.
// Define RS_BRANCH_AGE_EN to issue the oldest ready entry (age matrix); otherwise the lowest index issues.
module rs_branch_multi #(
    parameter int DEPTH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W = 4,
    parameter int OP_W = 6,
    parameter logic [TAG_W-1:0] TAG_FREE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_en,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [DATA_W-1:0] alloc_data1,
    input  logic [DATA_W-1:0] alloc_data2,
    input  logic [TAG_W-1:0]  alloc_tag1,
    input  logic [TAG_W-1:0]  alloc_tag2,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic [ADDR_W-1:0] alloc_offset,
    input  logic              stall,
    input  logic              flush,
    input  logic              en_alu_rst1,
    input  logic              en_alu_rst2,
    input  logic              en_mem_rst,
    input  logic [TAG_W-1:0]  alu_rst_tag1,
    input  logic [TAG_W-1:0]  alu_rst_tag2,
    input  logic [TAG_W-1:0]  mem_rst_tag,
    input  logic [DATA_W-1:0] alu_rst_data1,
    input  logic [DATA_W-1:0] alu_rst_data2,
    input  logic [DATA_W-1:0] mem_rst_data,
    output logic              full,
    output logic              ex_branch_en,
    output logic [DATA_W-1:0] exsrc1_out,
    output logic [DATA_W-1:0] exsrc2_out,
    output logic [ADDR_W-1:0] expc_out,
    output logic [ADDR_W-1:0] exoffset_out,
    output logic [OP_W-1:0]   exaluop_out
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  busy;
    logic [TAG_W-1:0]  tag1_q   [DEPTH];
    logic [TAG_W-1:0]  tag2_q   [DEPTH];
    logic [DATA_W-1:0] data1_q  [DEPTH];
    logic [DATA_W-1:0] data2_q  [DEPTH];
    logic [ADDR_W-1:0] pc_q     [DEPTH];
    logic [ADDR_W-1:0] offset_q [DEPTH];
    logic [OP_W-1:0]   op_q     [DEPTH];

    // Broadcast buses in wakeup priority order: index 0 wins (alu1, mem, alu2).
    logic [2:0]             bc_en;
    logic [2:0][TAG_W-1:0]  bc_tag;
    logic [2:0][DATA_W-1:0] bc_data;

    assign bc_en   = {en_alu_rst2, en_mem_rst, en_alu_rst1};
    assign bc_tag  = {alu_rst_tag2, mem_rst_tag, alu_rst_tag1};
    assign bc_data = {alu_rst_data2, mem_rst_data, alu_rst_data1};

    function automatic logic [DATA_W+TAG_W-1:0] snoop(
        input logic [TAG_W-1:0]        tag,
        input logic [DATA_W-1:0]       data,
        input logic [2:0]              en,
        input logic [2:0][TAG_W-1:0]   btag,
        input logic [2:0][DATA_W-1:0]  bdata
    );
        logic [DATA_W+TAG_W-1:0] res;
        res = {data, tag};
        if (tag != TAG_FREE) begin
            for (int k = 2; k >= 0; k--) begin
                if (en[k] && (btag[k] == tag)) res = {bdata[k], TAG_FREE};
            end
        end
        return res;
    endfunction

    logic [TAG_W-1:0]  wtag1  [DEPTH];
    logic [TAG_W-1:0]  wtag2  [DEPTH];
    logic [DATA_W-1:0] wdata1 [DEPTH];
    logic [DATA_W-1:0] wdata2 [DEPTH];
    logic [DEPTH-1:0]  ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {wdata1[i], wtag1[i]} = snoop(tag1_q[i], data1_q[i], bc_en, bc_tag, bc_data);
            {wdata2[i], wtag2[i]} = snoop(tag2_q[i], data2_q[i], bc_en, bc_tag, bc_data);
            ready[i] = busy[i] && (wtag1[i] == TAG_FREE) && (wtag2[i] == TAG_FREE);
        end
    end

    logic [TAG_W-1:0]  atag1, atag2;
    logic [DATA_W-1:0] adata1, adata2;

    assign {adata1, atag1} = snoop(alloc_tag1, alloc_data1, bc_en, bc_tag, bc_data);
    assign {adata2, atag2} = snoop(alloc_tag2, alloc_data2, bc_en, bc_tag, bc_data);

    // Free-slot search uses the registered busy bits, so a slot freed by this cycle's issue is not reused.
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_go;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign full     = &busy;
    assign alloc_go = alloc_en && !stall && !full && !flush && rdy;

    logic [DEPTH-1:0] pick;

`ifdef RS_BRANCH_AGE_EN
    // older[i][j] = 1 when entry i was allocated before entry j.
    logic [DEPTH-1:0] older [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pick[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready[j] && older[j][i]) pick[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (alloc_go) begin
            for (int j = 0; j < DEPTH; j++) begin
                older[alloc_idx][j] <= 1'b0;
                if (j != int'(alloc_idx)) older[j][alloc_idx] <= 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end
`endif

    logic [IDX_W-1:0] issue_idx;
    logic             issue_go;

    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pick[i]) issue_idx = IDX_W'(i);
        end
    end

    assign issue_go = rdy && !flush && (|pick);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag1_q[i]   <= TAG_FREE;
                tag2_q[i]   <= TAG_FREE;
                data1_q[i]  <= '0;
                data2_q[i]  <= '0;
                pc_q[i]     <= '0;
                offset_q[i] <= '0;
                op_q[i]     <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i]) begin
                        tag1_q[i]  <= wtag1[i];
                        tag2_q[i]  <= wtag2[i];
                        data1_q[i] <= wdata1[i];
                        data2_q[i] <= wdata2[i];
                    end
                end
                if (issue_go) busy[issue_idx] <= 1'b0;
                if (alloc_go) begin
                    busy[alloc_idx]     <= 1'b1;
                    tag1_q[alloc_idx]   <= atag1;
                    tag2_q[alloc_idx]   <= atag2;
                    data1_q[alloc_idx]  <= adata1;
                    data2_q[alloc_idx]  <= adata2;
                    pc_q[alloc_idx]     <= alloc_pc;
                    offset_q[alloc_idx] <= alloc_offset;
                    op_q[alloc_idx]     <= alloc_op;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_branch_en <= 1'b0;
            exsrc1_out   <= '0;
            exsrc2_out   <= '0;
            expc_out     <= '0;
            exoffset_out <= '0;
            exaluop_out  <= '0;
        end else if (rdy) begin
            if (issue_go) begin
                ex_branch_en <= 1'b1;
                exsrc1_out   <= wdata1[issue_idx];
                exsrc2_out   <= wdata2[issue_idx];
                expc_out     <= pc_q[issue_idx];
                exoffset_out <= offset_q[issue_idx];
                exaluop_out  <= op_q[issue_idx];
            end else begin
                ex_branch_en <= 1'b0;
                exsrc1_out   <= '0;
                exsrc2_out   <= '0;
                expc_out     <= '0;
                exoffset_out <= '0;
                exaluop_out  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rs_branch_multi.sv
// Self-checking bench for rs_branch_multi: scoreboard of expected issues plus per-scenario checks.
module tb_rs_branch_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        alloc_en = 1'b0;
    logic [5:0]  alloc_op = '0;
    logic [31:0] alloc_data1 = '0, alloc_data2 = '0;
    logic [3:0]  alloc_tag1 = '0, alloc_tag2 = '0;
    logic [31:0] alloc_pc = '0, alloc_offset = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        en_alu_rst1 = 1'b0, en_alu_rst2 = 1'b0, en_mem_rst = 1'b0;
    logic [3:0]  alu_rst_tag1 = '0, alu_rst_tag2 = '0, mem_rst_tag = '0;
    logic [31:0] alu_rst_data1 = '0, alu_rst_data2 = '0, mem_rst_data = '0;
    logic        full, ex_branch_en;
    logic [31:0] exsrc1_out, exsrc2_out, expc_out, exoffset_out;
    logic [5:0]  exaluop_out;

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] pc;
        logic [31:0] off;
        logic [5:0]  op;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic rdy_at_edge = 1'b0;

    rs_branch_multi dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_en(alloc_en), .alloc_op(alloc_op),
        .alloc_data1(alloc_data1), .alloc_data2(alloc_data2),
        .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
        .alloc_pc(alloc_pc), .alloc_offset(alloc_offset),
        .stall(stall), .flush(flush),
        .en_alu_rst1(en_alu_rst1), .en_alu_rst2(en_alu_rst2), .en_mem_rst(en_mem_rst),
        .alu_rst_tag1(alu_rst_tag1), .alu_rst_tag2(alu_rst_tag2), .mem_rst_tag(mem_rst_tag),
        .alu_rst_data1(alu_rst_data1), .alu_rst_data2(alu_rst_data2), .mem_rst_data(mem_rst_data),
        .full(full), .ex_branch_en(ex_branch_en),
        .exsrc1_out(exsrc1_out), .exsrc2_out(exsrc2_out),
        .expc_out(expc_out), .exoffset_out(exoffset_out), .exaluop_out(exaluop_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdy_at_edge <= rdy;

    // Every cycle whose edge had rdy=1: an issue must match the scoreboard head, idle outputs must be zero.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && rdy_at_edge) begin
            checks++;
            if (ex_branch_en) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue got pc=%h src1=%h expected no issue", expc_out, exsrc1_out);
                end else begin
                    e = sb.pop_front();
                    if ({exsrc1_out, exsrc2_out, expc_out, exoffset_out, exaluop_out} !== e) begin
                        errors++;
                        $display("FAIL issue_data got src1=%h src2=%h pc=%h off=%h op=%h expected src1=%h src2=%h pc=%h off=%h op=%h",
                                 exsrc1_out, exsrc2_out, expc_out, exoffset_out, exaluop_out,
                                 e.s1, e.s2, e.pc, e.off, e.op);
                    end
                end
            end else if ({exsrc1_out, exsrc2_out, expc_out, exoffset_out, exaluop_out} !== '0) begin
                errors++;
                $display("FAIL idle_outputs got src1=%h src2=%h pc=%h off=%h op=%h expected all 0",
                         exsrc1_out, exsrc2_out, expc_out, exoffset_out, exaluop_out);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        alloc_en = 0; stall = 0; flush = 0;
        alloc_op = '0; alloc_data1 = '0; alloc_data2 = '0; alloc_tag1 = '0; alloc_tag2 = '0;
        alloc_pc = '0; alloc_offset = '0;
        en_alu_rst1 = 0; en_alu_rst2 = 0; en_mem_rst = 0;
        alu_rst_tag1 = '0; alu_rst_tag2 = '0; mem_rst_tag = '0;
        alu_rst_data1 = '0; alu_rst_data2 = '0; mem_rst_data = '0;
    endtask

    task automatic set_alloc(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [3:0] t1, input logic [3:0] t2,
                             input logic [31:0] pc, input logic [31:0] off);
        alloc_en = 1; alloc_op = op; alloc_data1 = d1; alloc_data2 = d2;
        alloc_tag1 = t1; alloc_tag2 = t2; alloc_pc = pc; alloc_offset = off;
    endtask

    task automatic push_exp(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] pc,
                            input logic [31:0] off, input logic [5:0] op);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.pc = pc; e.off = off; e.op = op;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({full, ex_branch_en, exsrc1_out, exsrc2_out, expc_out, exoffset_out, exaluop_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got full=%b en=%b pc=%h expected all 0", full, ex_branch_en, expc_out);
        end
        #11;
        rst = 1;
        set_alloc(6'h01, 32'h11, 32'h22, 0, 0, 32'h40, 32'h4);
        push_exp(32'h11, 32'h22, 32'h40, 32'h4, 6'h01);
        step();
        clear_in();
        step();
        checks++;
        if (ex_branch_en !== 1'b1) begin
            errors++;
            $display("FAIL first_alloc_after_reset got en=%b expected 1", ex_branch_en);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_reset got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_basic();
        set_alloc(6'h04, 32'd5, 32'd5, 0, 0, 32'h100, 32'd8);
        push_exp(32'd5, 32'd5, 32'h100, 32'd8, 6'h04);
        step();
        clear_in();
        checks++;
        if (ex_branch_en !== 1'b0) begin errors++; $display("FAIL latency_early got en=%b expected 0", ex_branch_en); end
        step();
        checks++;
        if (ex_branch_en !== 1'b1) begin errors++; $display("FAIL latency_one got en=%b expected 1", ex_branch_en); end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_basic got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_wakeup();
        set_alloc(6'h05, 32'hdead, 32'd7, 4'd3, 0, 32'h200, 32'h10);
        step();
        clear_in();
        step();
        checks++;
        if (ex_branch_en !== 1'b0) begin errors++; $display("FAIL wait_tag got en=%b expected 0", ex_branch_en); end
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd3; alu_rst_data2 = 32'h55;
        set_alloc(6'h06, 32'hbeef, 32'd9, 4'd3, 0, 32'h300, 32'h20);
        push_exp(32'h55, 32'd7, 32'h200, 32'h10, 6'h05);
        push_exp(32'h55, 32'd9, 32'h300, 32'h20, 6'h06);
        step();
        clear_in();
        checks++;
        if (ex_branch_en !== 1'b1) begin errors++; $display("FAIL wake_bypass got en=%b expected 1", ex_branch_en); end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_wakeup got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_priority();
        set_alloc(6'h07, 0, 0, 4'd5, 4'd5, 32'h400, 32'h4);
        step();
        clear_in();
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd5; alu_rst_data1 = 32'hA1;
        en_mem_rst  = 1; mem_rst_tag  = 4'd5; mem_rst_data  = 32'hB2;
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd5; alu_rst_data2 = 32'hC3;
        push_exp(32'hA1, 32'hA1, 32'h400, 32'h4, 6'h07);
        step();
        clear_in();
        set_alloc(6'h08, 0, 0, 4'd6, 4'd6, 32'h404, 32'h4);
        step();
        clear_in();
        en_mem_rst  = 1; mem_rst_tag  = 4'd6; mem_rst_data  = 32'hB2;
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd6; alu_rst_data2 = 32'hC3;
        push_exp(32'hB2, 32'hB2, 32'h404, 32'h4, 6'h08);
        step();
        clear_in();
        set_alloc(6'h09, 0, 0, 4'd7, 4'd8, 32'h408, 32'h4);
        step();
        clear_in();
        en_mem_rst  = 1; mem_rst_tag  = 4'd8; mem_rst_data  = 32'hB8;
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd7; alu_rst_data2 = 32'hC7;
        push_exp(32'hC7, 32'hB8, 32'h408, 32'h4, 6'h09);
        step();
        clear_in();
        set_alloc(6'h0A, 32'd1, 32'd2, 0, 0, 32'h500, 32'h8);
        en_alu_rst1 = 1; alu_rst_tag1 = 0; alu_rst_data1 = 32'hFF;
        en_mem_rst  = 1; mem_rst_tag  = 0; mem_rst_data  = 32'hFE;
        push_exp(32'd1, 32'd2, 32'h500, 32'h8, 6'h0A);
        step();
        clear_in();
        set_alloc(6'h0B, 0, 32'h22, 4'd9, 0, 32'h504, 32'h8);
        step();
        clear_in();
        en_alu_rst1 = 1; alu_rst_tag1 = 0; alu_rst_data1 = 32'hEE;
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd9; alu_rst_data2 = 32'h99;
        push_exp(32'h99, 32'h22, 32'h504, 32'h8, 6'h0B);
        step();
        clear_in();
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_priority got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_alloc(6'(i), 32'hF0 + 32'(i), 32'(i), 4'(i + 1), 0, 32'h600 + 32'(4 * i), 0);
            step();
        end
        clear_in();
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_set got full=%b expected 1", full); end
        set_alloc(6'h3F, 32'h77, 32'h77, 0, 0, 32'h700, 0);
        step();
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_hold got full=%b expected 1", full); end
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd2; alu_rst_data1 = 32'h2222;
        push_exp(32'h2222, 32'd1, 32'h604, 0, 6'd1);
        #1;
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_same_cycle got full=%b expected 1", full); end
        step();
        clear_in();
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL full_next_cycle got full=%b expected 0", full); end
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd1; alu_rst_data1 = 32'h1111;
        en_mem_rst  = 1; mem_rst_tag  = 4'd3; mem_rst_data  = 32'h3333;
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd4; alu_rst_data2 = 32'h4444;
        push_exp(32'h1111, 32'd0, 32'h600, 0, 6'd0);
        push_exp(32'h3333, 32'd2, 32'h608, 0, 6'd2);
        push_exp(32'h4444, 32'd3, 32'h60C, 0, 6'd3);
        step();
        clear_in();
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_full got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_age();
        set_alloc(6'h10, 0, 32'hA, 4'd5, 0, 32'h800, 0); step();
        set_alloc(6'h11, 0, 32'hB, 4'd6, 0, 32'h804, 0); step();
        set_alloc(6'h12, 0, 32'hC, 4'd7, 0, 32'h808, 0); step();
        clear_in();
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd5; alu_rst_data1 = 32'h50;
        push_exp(32'h50, 32'hA, 32'h800, 0, 6'h10);
        step();
        clear_in();
        set_alloc(6'h13, 0, 32'hD, 4'd7, 0, 32'h80C, 0);
        step();
        clear_in();
        en_mem_rst = 1; mem_rst_tag = 4'd7; mem_rst_data = 32'h70;
`ifdef RS_BRANCH_AGE_EN
        push_exp(32'h70, 32'hC, 32'h808, 0, 6'h12);
        push_exp(32'h70, 32'hD, 32'h80C, 0, 6'h13);
`else
        push_exp(32'h70, 32'hD, 32'h80C, 0, 6'h13);
        push_exp(32'h70, 32'hC, 32'h808, 0, 6'h12);
`endif
        step();
        clear_in();
        step();
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd6; alu_rst_data2 = 32'h60;
        push_exp(32'h60, 32'hB, 32'h804, 0, 6'h11);
        step();
        clear_in();
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_age got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_flush();
        set_alloc(6'h20, 0, 0, 4'd1, 0, 32'h900, 0); step();
        set_alloc(6'h21, 0, 0, 4'd2, 0, 32'h904, 0); step();
        set_alloc(6'h22, 0, 0, 4'd3, 0, 32'h908, 0); step();
        clear_in();
        flush = 1;
        set_alloc(6'h23, 32'h1, 32'h2, 0, 0, 32'h9F0, 0);
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd1; alu_rst_data1 = 32'h111;
        step();
        clear_in();
        checks++;
        if ({full, ex_branch_en} !== 2'b00) begin
            errors++;
            $display("FAIL flush_clear got full=%b en=%b expected 0 0", full, ex_branch_en);
        end
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd2; alu_rst_data1 = 32'h222;
        en_mem_rst  = 1; mem_rst_tag  = 4'd3; mem_rst_data  = 32'h333;
        step();
        clear_in();
        step();
        checks++;
        if (ex_branch_en !== 1'b0) begin errors++; $display("FAIL flush_no_issue got en=%b expected 0", ex_branch_en); end
        set_alloc(6'h24, 32'h3, 32'h4, 0, 0, 32'h9A0, 0);
        push_exp(32'h3, 32'h4, 32'h9A0, 0, 6'h24);
        step();
        clear_in();
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_flush got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_hold();
        set_alloc(6'h09, 0, 32'd1, 4'd9, 0, 32'hA00, 32'h40);
        step();
        clear_in();
        rdy = 0;
        set_alloc(6'h2F, 32'h5, 32'h5, 0, 0, 32'hAFF, 0);
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd9; alu_rst_data1 = 32'h99;
        step();
        step();
        clear_in();
        rdy = 1;
        step();
        step();
        checks++;
        if (ex_branch_en !== 1'b0) begin errors++; $display("FAIL hold_ignore_bcast got en=%b expected 0", ex_branch_en); end
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd9; alu_rst_data1 = 32'h9A;
        push_exp(32'h9A, 32'd1, 32'hA00, 32'h40, 6'h09);
        step();
        clear_in();
        rdy = 0;
        checks++;
        if (ex_branch_en !== 1'b1) begin errors++; $display("FAIL hold_issue got en=%b expected 1", ex_branch_en); end
        step();
        checks++;
        if ({ex_branch_en, expc_out} !== {1'b1, 32'hA00}) begin
            errors++;
            $display("FAIL hold_outputs got en=%b pc=%h expected 1 00000a00", ex_branch_en, expc_out);
        end
        rdy = 1;
        step();
        checks++;
        if (ex_branch_en !== 1'b0) begin errors++; $display("FAIL hold_release got en=%b expected 0", ex_branch_en); end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_hold got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            set_alloc(6'(i + 32), 32'(i * 3), 32'(i * 5), 0, 0, 32'hC00 + 32'(4 * i), 32'(i));
            stall = (i == 3);
            if (i != 3) push_exp(32'(i * 3), 32'(i * 5), 32'hC00 + 32'(4 * i), 32'(i), 6'(i + 32));
            step();
        end
        clear_in();
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_b2b got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(6'h30, 0, 0, 4'(i + 1), 0, 32'hB80 + 32'(4 * i), 0);
            step();
        end
        clear_in();
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL rst_pre_full got full=%b expected 1", full); end
        #1;
        rst = 0;
        #1;
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL rst_async_full got full=%b expected 0", full); end
        #3;
        rst = 1;
        sb.delete();
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd1; alu_rst_data1 = 32'h1;
        en_mem_rst  = 1; mem_rst_tag  = 4'd2; mem_rst_data  = 32'h2;
        en_alu_rst2 = 1; alu_rst_tag2 = 4'd3; alu_rst_data2 = 32'h3;
        step();
        clear_in();
        step();
        checks++;
        if ({full, ex_branch_en} !== 2'b00) begin
            errors++;
            $display("FAIL rst_empty got full=%b en=%b expected 0 0", full, ex_branch_en);
        end
        set_alloc(6'h31, 32'h7, 32'h8, 0, 0, 32'hB00, 0);
        step();
        set_alloc(6'h32, 0, 0, 4'd5, 0, 32'hB04, 0);
        step();
        clear_in();
        checks++;
        if (ex_branch_en !== 1'b1) begin errors++; $display("FAIL rst_pre_issue got en=%b expected 1", ex_branch_en); end
        rst = 0;
        #1;
        checks++;
        if ({ex_branch_en, exsrc1_out, expc_out} !== '0) begin
            errors++;
            $display("FAIL rst_async_issue got en=%b src1=%h pc=%h expected 0", ex_branch_en, exsrc1_out, expc_out);
        end
        #3;
        rst = 1;
        en_alu_rst1 = 1; alu_rst_tag1 = 4'd5; alu_rst_data1 = 32'h5;
        step();
        clear_in();
        step();
        checks++;
        if (ex_branch_en !== 1'b0) begin errors++; $display("FAIL rst_no_recovery got en=%b expected 0", ex_branch_en); end
        set_alloc(6'h33, 32'h9, 32'hA, 0, 0, 32'hB10, 0);
        push_exp(32'h9, 32'hA, 32'hB10, 0, 6'h33);
        step();
        clear_in();
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_rst got pending=%0d expected 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_priority();
        test_full();
        test_age();
        test_flush();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
